// File: rtl/sseg_pkg.sv
// Shared seven-segment encodings and anode/dp polarity for the scan driver.
package sseg_pkg;

  // Active-low gfedcba glyphs
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Anodes and the decimal point are active-low on the board
  localparam logic ANODE_OFF = 1'b1;
  localparam logic ANODE_ON  = 1'b0;
  localparam logic DP_OFF    = 1'b1;

  // Full hex glyph lookup; decimal-mode suppression is applied by the caller
  function automatic logic [6:0] seg_lut(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sseg_scan_driver_if.sv
// Data-in / display-out bundle of the scan driver.
interface sseg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   value;
  logic [NUM_DIGITS-1:0]     dp_in;
  logic                      blank_lz;
  logic [NUM_DIGITS-1:0]     an;
  logic [6:0]                seg;
  logic                      dp;
  logic                      frame_done;

  // Datapath side: supplies the value, watches the display
  modport master (
    output load, value, dp_in, blank_lz,
    input  an, seg, dp, frame_done
  );

  // Driver side
  modport slave (
    input  load, value, dp_in, blank_lz,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/sseg_decode.sv
// Nibble to active-low segment pattern, with forced blank and decimal mode.
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  output logic [6:0] seg
);

  // Glyph lookup; leading-zero blank or a non-decimal nibble in decimal mode goes dark
  always_comb begin
    seg = seg_lut(nibble);
    if (blank || (!hex_mode && (nibble > 4'd9)))
      seg = SEG_BLANK;
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Multiplexed N-digit seven-segment driver: shadow capture, slot timing,
// leading-zero blanking and registered anode/segment outputs.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2,
  parameter int HEX_MODE     = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  sseg_scan_driver_if.slave  bus
);

  localparam int             CW       = $clog2(REFRESH_DIV);
  localparam int             IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0]  IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic           HEX      = (HEX_MODE != 0);

  logic [CW-1:0]                 cnt;
  logic [IW-1:0]                 idx;
  logic [NUM_DIGITS-1:0][3:0]    sh_val;
  logic [NUM_DIGITS-1:0]         sh_dp;
  logic                          sh_lz;

  logic                          slot_end;
  logic                          frame_end;
  logic                          in_blank;
  logic [NUM_DIGITS-1:0]         blank_vec;
  logic                          zero_run;
  logic [3:0]                    nib;
  logic [6:0]                    dec_seg;
  logic [NUM_DIGITS-1:0]         an_sel;

  logic [NUM_DIGITS-1:0]         an_q;
  logic [6:0]                    seg_q;
  logic                          dp_q;
  logic                          fd_q;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == IDX_LAST);

  // Anti-ghosting window at the head of each slot; absent when BLANK_CYCLES is 0
  generate
    if (BLANK_CYCLES > 0) begin : g_blank
      assign in_blank = (cnt < CW'(BLANK_CYCLES));
    end else begin : g_noblank
      assign in_blank = 1'b0;
    end
  endgenerate

  // Slot counter and digit index; index advances when a slot wraps
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Shadow registers: display content only changes on load
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_val <= '0;
      sh_dp  <= '0;
      sh_lz  <= 1'b0;
    end else if (bus.load) begin
      sh_val <= bus.value;
      sh_dp  <= bus.dp_in;
      sh_lz  <= bus.blank_lz;
    end
  end

  // Leading-zero mask: walk down from the top digit while everything seen is zero;
  // digit 0 is never masked so an all-zero value still shows "0"
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run = zero_run & (sh_val[i] == 4'd0);
      if (i != 0)
        blank_vec[i] = sh_lz & zero_run;
    end
  end

  assign nib    = sh_val[idx];
  assign an_sel = ~(NUM_DIGITS'(1) << idx);

  sseg_decode u_dec (
    .nibble   (nib),
    .hex_mode (HEX),
    .blank    (blank_vec[idx]),
    .seg      (dec_seg)
  );

  // Registered pin drive, one cycle behind counter/index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q  <= {NUM_DIGITS{ANODE_OFF}};
      seg_q <= SEG_BLANK;
      dp_q  <= DP_OFF;
      fd_q  <= 1'b0;
    end else begin
      fd_q <= frame_end;
      if (in_blank) begin
        an_q  <= {NUM_DIGITS{ANODE_OFF}};
        seg_q <= SEG_BLANK;
        dp_q  <= DP_OFF;
      end else begin
        an_q  <= an_sel;
        seg_q <= dec_seg;
        dp_q  <= ~sh_dp[idx];
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: three configurations checked every cycle against
// a slot-arithmetic model, plus directed literal expectations.
module tb_sseg_scan_driver;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sseg_scan_driver_if #(.NUM_DIGITS(4)) ifa ();
  sseg_scan_driver_if #(.NUM_DIGITS(4)) ifb ();
  sseg_scan_driver_if #(.NUM_DIGITS(1)) ifc ();

  sseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(1))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  sseg_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .HEX_MODE(0))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));
  sseg_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(3), .BLANK_CYCLES(0), .HEX_MODE(1))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(ifc));

  localparam int ND [3] = '{4, 4, 1};
  localparam int RD [3] = '{4, 4, 3};
  localparam int BC [3] = '{1, 1, 0};
  localparam int HX [3] = '{1, 0, 1};

  logic [6:0] segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] antab [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each DUT is described by the number of edges since reset (t) and the last
  // loaded shadow. Output after an edge depends on the position of the previous
  // state within the frame: pos = t mod (slots*digits).
  int          t   [3];
  logic [31:0] shv [3];
  logic [7:0]  shd [3];
  logic        shl [3];
  logic [7:0]  e_an  [3];
  logic [6:0]  e_seg [3];
  logic        e_dp  [3];
  logic        e_fd  [3];

  // Model update on every edge, reset asynchronously like the design
  always @(posedge clk or negedge rst_n) begin : model
    int pos, idx, cnt, nib;
    logic [7:0]  msk, an_x;
    logic [6:0]  seg_x;
    logic        dp_x;
    logic [31:0] above;
    logic        ld   [3];
    logic [31:0] vin  [3];
    logic [7:0]  din  [3];
    logic        lzin [3];
    ld[0] = ifa.load; vin[0] = 32'(ifa.value); din[0] = 8'(ifa.dp_in); lzin[0] = ifa.blank_lz;
    ld[1] = ifb.load; vin[1] = 32'(ifb.value); din[1] = 8'(ifb.dp_in); lzin[1] = ifb.blank_lz;
    ld[2] = ifc.load; vin[2] = 32'(ifc.value); din[2] = 8'(ifc.dp_in); lzin[2] = ifc.blank_lz;
    for (int d = 0; d < 3; d++) begin
      msk = 8'((1 << ND[d]) - 1);
      if (!rst_n) begin
        t[d] <= 0; shv[d] <= '0; shd[d] <= '0; shl[d] <= 1'b0;
        e_an[d] <= msk; e_seg[d] <= 7'h7F; e_dp[d] <= 1'b1; e_fd[d] <= 1'b0;
      end else begin
        pos = t[d] % (RD[d] * ND[d]);
        idx = pos / RD[d];
        cnt = pos % RD[d];
        if (cnt < BC[d]) begin
          an_x = msk; seg_x = 7'h7F; dp_x = 1'b1;
        end else begin
          an_x  = ~(8'd1 << idx) & msk;
          above = shv[d] >> (4 * idx);
          nib   = int'(above & 32'hF);
          if (shl[d] && idx != 0 && above == 0) seg_x = 7'h7F;
          else if (HX[d] == 0 && nib > 9)       seg_x = 7'h7F;
          else                                  seg_x = segtab[nib];
          dp_x = ~shd[d][idx];
        end
        e_an[d]  <= an_x;
        e_seg[d] <= seg_x;
        e_dp[d]  <= dp_x;
        e_fd[d]  <= (pos == RD[d] * ND[d] - 1);
        t[d]     <= t[d] + 1;
        if (ld[d]) begin
          shv[d] <= vin[d]; shd[d] <= din[d]; shl[d] <= lzin[d];
        end
      end
    end
  end

  // Per-cycle comparison of all three DUTs against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_a", {15'd0, 8'(ifa.an), ifa.seg, ifa.dp, ifa.frame_done},
                   {15'd0, e_an[0], e_seg[0], e_dp[0], e_fd[0]});
      chk("cyc_b", {15'd0, 8'(ifb.an), ifb.seg, ifb.dp, ifb.frame_done},
                   {15'd0, e_an[1], e_seg[1], e_dp[1], e_fd[1]});
      chk("cyc_c", {15'd0, 8'(ifc.an), ifc.seg, ifc.dp, ifc.frame_done},
                   {15'd0, e_an[2], e_seg[2], e_dp[2], e_fd[2]});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic load_ab(input logic [15:0] v, input logic [3:0] dpv, input logic lz);
    @(negedge clk);
    ifa.load = 1'b1; ifa.value = v; ifa.dp_in = dpv; ifa.blank_lz = lz;
    ifb.load = 1'b1; ifb.value = v; ifb.dp_in = dpv; ifb.blank_lz = lz;
    @(negedge clk);
    ifa.load = 1'b0; ifb.load = 1'b0;
  endtask

  // Returns at the negedge where frame_done of DUT A is seen high
  task automatic wait_fd(input string nm);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ifa.frame_done === 1'b1) return;
    end
    n_chk++; n_fail++;
    $display("FAIL %s: frame_done timeout, got none, expected pulse within 100 cycles", nm);
  endtask

  // One full frame of DUT d with literal segment table {d3,d2,d1,d0}
  task automatic check_frame(input int d, input logic [27:0] segs,
                             input logic [3:0] dpx, input string nm);
    logic [3:0] an_g;
    logic [6:0] seg_g;
    logic       dp_g, fd_g;
    int         pos, dg;
    wait_fd(nm);
    for (int j = 1; j <= 16; j++) begin
      @(negedge clk);
      an_g  = (d == 0) ? ifa.an  : ifb.an;
      seg_g = (d == 0) ? ifa.seg : ifb.seg;
      dp_g  = (d == 0) ? ifa.dp  : ifb.dp;
      fd_g  = (d == 0) ? ifa.frame_done : ifb.frame_done;
      pos = j - 1;
      dg  = pos / 4;
      if (pos % 4 == 0)
        chk({nm, "_gap"}, {20'd0, an_g, seg_g, dp_g}, {20'd0, 4'hF, 7'h7F, 1'b1});
      else
        chk({nm, "_dig"}, {20'd0, an_g, seg_g, dp_g}, {20'd0, antab[dg], segs[7*dg +: 7], ~dpx[dg]});
      chk({nm, "_fd"}, 32'(fd_g), 32'(j == 16));
    end
  endtask

  initial begin
    int fdc;
    ifa.load = 0; ifa.value = '0; ifa.dp_in = '0; ifa.blank_lz = 0;
    ifb.load = 0; ifb.value = '0; ifb.dp_in = '0; ifb.blank_lz = 0;
    ifc.load = 0; ifc.value = '0; ifc.dp_in = '0; ifc.blank_lz = 0;
    repeat (2) @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_a", {20'd0, ifa.an, ifa.seg, ifa.dp}, {20'd0, 4'hF, 7'h7F, 1'b1});
    chk("rst_fd", 32'(ifa.frame_done), 32'd0);
    chk("rst_c_an", 32'(ifc.an), 32'd1);

    // release reset and load the single-digit instance
    rst_n = 1'b1;
    ifc.load = 1'b1; ifc.value = 4'h3; ifc.dp_in = 1'b1;
    @(negedge clk);
    ifc.load = 1'b0;

    // single digit: anode always on, frame_done every 3 cycles
    fdc = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      chk("c_out", {23'd0, ifc.an, ifc.seg, ifc.dp}, {23'd0, 1'b0, 7'h30, 1'b0});
      if (ifc.frame_done) fdc++;
    end
    chk("c_fd_count", 32'(fdc), 32'd3);

    // basic scan
    load_ab(16'h1234, 4'b0000, 1'b0);
    check_frame(0, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b0000, "s1");

    // leading-zero blanking, dp on blanked digit
    load_ab(16'h00A5, 4'b0000, 1'b1);
    check_frame(0, {7'h7F, 7'h7F, 7'h08, 7'h12}, 4'b0000, "s2");
    load_ab(16'h0000, 4'b1000, 1'b1);
    check_frame(0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1000, "s2z");

    // decimal mode instance
    load_ab(16'hF907, 4'b0010, 1'b0);
    check_frame(1, {7'h7F, 7'h10, 7'h40, 7'h78}, 4'b0010, "s3");

    // load exactly on a slot wrap edge
    wait_fd("s4");
    repeat (3) @(negedge clk);
    ifa.load = 1'b1; ifa.value = 16'h5618; ifa.dp_in = 4'b0000;
    ifb.load = 1'b1; ifb.value = 16'h5618; ifb.dp_in = 4'b0000;
    @(negedge clk);
    ifa.load = 1'b0; ifb.load = 1'b0;
    chk("s4_old", {24'd0, ifa.an, ifa.seg}, {24'd0, 4'hE, 7'h78});
    ifa.value = 16'hFFFF; ifb.value = 16'hFFFF;
    repeat (2) @(negedge clk);
    chk("s4_new", {24'd0, ifa.an, ifa.seg}, {24'd0, 4'hD, 7'h79});
    check_frame(0, {7'h12, 7'h02, 7'h79, 7'h00}, 4'b0000, "s4h");

    // asynchronous reset on digit 2
    wait_fd("s5");
    repeat (10) @(negedge clk);
    chk("s5_pre", 32'(ifa.an), 32'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async", {20'd0, ifa.an, ifa.seg, ifa.dp}, {20'd0, 4'hF, 7'h7F, 1'b1});
    chk("s5_async_b", 32'(ifb.an), 32'hF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("s5_gap", 32'(ifa.an), 32'hF);
    @(negedge clk);
    chk("s5_d0", {20'd0, ifa.an, ifa.seg, ifa.dp}, {20'd0, 4'hE, 7'h40, 1'b1});
    repeat (4) @(negedge clk);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
